regfile_mux_rd: RTL and testbench

//  Parametrised register file with NREAD independent read ports, each an

---
 rtl/regfile_mux_rd.sv | 126 ++++++++++++
 tb/tb_regfile_mux_rd.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mux_rd.sv
// Register file with NREAD independent indexed read ports, one synchronous write port,
// hardwired zero register, write-to-read bypass, optional registered reads and a post-reset clear sweep.
module regfile_mux_rd #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NREAD     = 2,
  parameter int unsigned REG_READ  = 0,
  parameter int unsigned ZERO_REG0 = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    clr_ptr;
  logic [AW-1:0]    clr_ptr_nxt;
  logic             ready_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we_c;
  logic [AW-1:0]    mem_waddr_c;
  logic [WIDTH-1:0] mem_wdata_c;
  logic             wr_ok_c;

  // Address maps to real, writable/readable storage (in range, not the zero register).
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG0 != 0) && (a == '0));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      ready   <= ready_nxt;
    end
  end

  // Clear sweep owns the write port until every word has been zeroed.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    ready_nxt   = ready;
    mem_we_c    = 1'b0;
    mem_waddr_c = waddr;
    mem_wdata_c = wdata;
    wr_ok_c     = 1'b0;
    case (state)
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_ptr;
        mem_wdata_c = '0;
        clr_ptr_nxt = clr_ptr + AW'(1);
        if (clr_ptr == AW'(DEPTH - 1)) begin
          state_nxt   = RUN;
          ready_nxt   = 1'b1;
          clr_ptr_nxt = '0;
        end
      end
      RUN: begin
        wr_ok_c  = we && addr_live(waddr);
        mem_we_c = wr_ok_c;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Storage is intentionally not reset; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]    addr_c;
    logic [WIDTH-1:0] word_c;

    assign addr_c = raddr[p*AW +: AW];

    // Bypass returns the word being written this cycle, so reads are write-first.
    always_comb begin
      word_c = '0;
      if ((state == RUN) && addr_live(addr_c)) begin
        if (wr_ok_c && (waddr == addr_c)) begin
          word_c = wdata;
        end else begin
          word_c = mem[addr_c];
        end
      end
    end

    if (REG_READ != 0) begin : g_reg
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q <= '0;
        end else begin
          rd_q <= word_c;
        end
      end
      assign rdata[p*WIDTH +: WIDTH] = rd_q;
    end else begin : g_comb
      assign rdata[p*WIDTH +: WIDTH] = word_c;
    end
  end

endmodule

// File: tb/tb_regfile_mux_rd.sv
// Directed bench for regfile_mux_rd: combinational, registered and DEPTH=20 instances share stimulus.
module tb_regfile_mux_rd;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        we2;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;

  logic        rdy0, rdy1, rdy2;
  logic [63:0] rd0, rd1, rd2;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_mux_rd #(.WIDTH(32), .DEPTH(32), .NREAD(2), .REG_READ(0), .ZERO_REG0(1)) u0 (
    .clk(clk), .reset(reset), .ready(rdy0), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rd0));

  regfile_mux_rd #(.WIDTH(32), .DEPTH(32), .NREAD(2), .REG_READ(1), .ZERO_REG0(1)) u1 (
    .clk(clk), .reset(reset), .ready(rdy1), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rd1));

  regfile_mux_rd #(.WIDTH(32), .DEPTH(20), .NREAD(2), .REG_READ(0), .ZERO_REG0(1)) u2 (
    .clk(clk), .reset(reset), .ready(rdy2), .we(we2), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rd2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp32(input int i);
    return (i == 0) ? 32'h0 : (32'hA500_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] exp20(input int i);
    return (i == 0 || i >= 20) ? 32'h0 : (32'hA500_0000 | 32'(i));
  endfunction

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    we2   = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    tick();
    check("rst_ready0", 32'(rdy0), 32'd0);
    check("rst_ready1", 32'(rdy1), 32'd0);
    check("rst_ready2", 32'(rdy2), 32'd0);
    check("rst_rd1", rd1[31:0], 32'h0);

    // Sweep: ready rises exactly DEPTH edges after reset release; an attempted write on the last sweep edge is ignored.
    reset = 1'b0;
    raddr = {5'd2, 5'd1};
    for (int e = 1; e <= 32; e++) begin
      if (e == 32) begin
        we = 1'b1; waddr = 5'd7; wdata = 32'd9;
      end
      tick();
      check($sformatf("sweep_ready0_e%0d", e), 32'(rdy0), 32'(e >= 32));
      check($sformatf("sweep_ready1_e%0d", e), 32'(rdy1), 32'(e >= 32));
      check($sformatf("sweep_ready2_e%0d", e), 32'(rdy2), 32'(e >= 20));
      if (e == 1) begin
        check("sweep_rd0", rd0[31:0], 32'h0);
        check("sweep_rd1", rd1[31:0], 32'h0);
      end
    end
    we = 1'b0;

    // Write to the zero register in RUN is dropped.
    we = 1'b1; waddr = 5'd0; wdata = 32'd1;
    tick();
    we = 1'b0;
    raddr = {5'd7, 5'd0};
    tick();
    check("z_u0_r0", rd0[31:0], 32'h0);
    check("z_u0_r7", rd0[63:32], 32'h0);
    check("z_u1_r0", rd1[31:0], 32'h0);
    check("z_u1_r7", rd1[63:32], 32'h0);
    check("z_u2_r7", rd2[63:32], 32'h0);

    // Fill every address, then sweep both ports in opposite directions.
    we = 1'b1; we2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      waddr = 5'(i);
      wdata = 32'hA500_0000 | 32'(i);
      tick();
    end
    we = 1'b0; we2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      tick();
      check($sformatf("rd_u0p0_a%0d", i), rd0[31:0], exp32(i));
      check($sformatf("rd_u0p1_a%0d", 31 - i), rd0[63:32], exp32(31 - i));
      check($sformatf("rd_u1p0_a%0d", i), rd1[31:0], exp32(i));
      check($sformatf("rd_u2p0_a%0d", i), rd2[31:0], exp20(i));
    end

    // Independent ports, same-cycle, and shared address.
    raddr = {5'd30, 5'd3};
    #1;
    check("ports_p0_3", rd0[31:0], exp32(3));
    check("ports_p1_30", rd0[63:32], exp32(30));
    check("ports_u2_p1_30", rd2[63:32], 32'h0);
    raddr = {5'd9, 5'd9};
    #1;
    check("same_p0", rd0[31:0], exp32(9));
    check("same_p1", rd0[63:32], exp32(9));
    check("same_u2_p1", rd2[63:32], exp20(9));

    // Bypass: combinational ports see wdata before the edge, registered port after it.
    raddr = {5'd6, 5'd5};
    we = 1'b1; we2 = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    #1;
    check("byp_u0_p0", rd0[31:0], 32'hDEADBEEF);
    check("byp_u0_p1", rd0[63:32], exp32(6));
    check("byp_u2_p0", rd2[31:0], 32'hDEADBEEF);
    check("byp_u1_pre", rd1[31:0], exp32(31));
    tick();
    check("byp_u1_post", rd1[31:0], 32'hDEADBEEF);
    check("byp_u1_p1", rd1[63:32], exp32(6));
    we = 1'b0; we2 = 1'b0;
    #1;
    check("byp_u0_stored", rd0[31:0], 32'hDEADBEEF);

    // No bypass into register 0.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr = {5'd6, 5'd0};
    #1;
    check("byp_z_u0", rd0[31:0], 32'h0);
    tick();
    check("byp_z_u1", rd1[31:0], 32'h0);
    we = 1'b0;

    // Out-of-range write and read on the DEPTH=20 instance.
    we2 = 1'b1; waddr = 5'd25; wdata = 32'd123; raddr = {5'd19, 5'd25};
    #1;
    check("oor_byp_u2", rd2[31:0], 32'h0);
    tick();
    we2 = 1'b0;
    #1;
    check("oor_rd_u2", rd2[31:0], 32'h0);
    check("oor_u2_r19", rd2[63:32], exp20(19));

    // Reset mid-operation wipes contents via a fresh sweep.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_ready0", 32'(rdy0), 32'd0);
    check("rst2_rd1", rd1[31:0], 32'h0);
    for (int e = 1; e <= 32; e++) begin
      tick();
      check($sformatf("rst2_ready0_e%0d", e), 32'(rdy0), 32'(e >= 32));
      check($sformatf("rst2_ready2_e%0d", e), 32'(rdy2), 32'(e >= 20));
    end
    raddr = {5'd5, 5'd7};
    tick();
    check("rst2_u0_r7", rd0[31:0], 32'h0);
    check("rst2_u0_r5", rd0[63:32], 32'h0);
    check("rst2_u1_r7", rd1[31:0], 32'h0);
    check("rst2_u2_r7", rd2[31:0], 32'h0);
    check("rst2_u2_r5", rd2[63:32], 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
